// File: rtl/br_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// br_tx_arbiter_if
//
// Bundles the requester-side and BrLite-side handshake signals of the
// BrLite transmit arbiter.
//
//   Requester side : req_i   [N_REQ]      level send request per requester
//                    data_i  [N_REQ]      packet per requester
//                    gnt_o   [N_REQ]      one-cycle pulse when a packet is taken
//   BrLite side    : br_local_busy_i      BrLite local port busy
//                    br_req_o             send request to BrLite
//                    br_ack_i             send acknowledge from BrLite
//                    br_data_o            packet presented to BrLite
//
// Modports:
//   master : the arbiter's view (drives gnt_o, br_req_o, br_data_o)
//   slave  : the surrounding system's view (requesters plus BrLite)
// ---------------------------------------------------------------------------
interface br_tx_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int PAYLOAD_W = 32
);

  typedef logic [PAYLOAD_W-1:0] br_payload_t;

  logic        [N_REQ-1:0] req_i;
  br_payload_t [N_REQ-1:0] data_i;
  logic        [N_REQ-1:0] gnt_o;
  logic                    br_local_busy_i;
  logic                    br_req_o;
  logic                    br_ack_i;
  br_payload_t             br_data_o;

  modport master (
    input  req_i,
    input  data_i,
    output gnt_o,
    input  br_local_busy_i,
    output br_req_o,
    input  br_ack_i,
    output br_data_o
  );

  modport slave (
    output req_i,
    output data_i,
    input  gnt_o,
    output br_local_busy_i,
    input  br_req_o,
    output br_ack_i,
    input  br_data_o
  );

endinterface

// File: rtl/br_tx_arbiter.sv
// ---------------------------------------------------------------------------
// br_tx_arbiter
//
// Round-robin arbiter that funnels N_REQ packet requesters into the single
// BrLite send port. A winner is chosen in IDLE, its packet is latched and
// offered to BrLite in REQ until acknowledged, then a one-cycle GAP
// separates consecutive requests.
//
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous, active-low reset
//   bus       : br_tx_arbiter_if.master (requester and BrLite handshakes)
//   busy_o    : high whenever the arbiter is not in IDLE
//   timeout_o : one-cycle pulse when an ack wait is abandoned
//
// Parameters:
//   N_REQ          : number of requesters (2..8)
//   TIMEOUT_CYCLES : ack wait limit in REQ cycles (timeout build only)
//   PAYLOAD_W      : width of br_payload_t
//
// Build option:
//   BR_TX_TIMEOUT_EN : when defined, REQ gives up after TIMEOUT_CYCLES
//                      cycles without ack; otherwise REQ waits forever and
//                      timeout_o is tied low.
// ---------------------------------------------------------------------------
module br_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PAYLOAD_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  br_tx_arbiter_if.master  bus,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef logic [PAYLOAD_W-1:0] br_payload_t;

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  br_payload_t        data_q, data_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   cand;

`ifdef BR_TX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // Round-robin search starting just after the last-served index. The loop
  // walks offsets from farthest to nearest so the nearest requesting index
  // is the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable driven here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    pick     = rr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_q) + i) % N_REQ);
      if (bus.req_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_d      = rr_q;
    data_d    = data_q;
    gnt_d     = '0;
`ifdef BR_TX_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld && !bus.br_local_busy_i) begin
          state_d  = ST_REQ;
          winner_d = pick;
          // The packet is captured here so later changes on data_i or a
          // dropped req_i cannot disturb the transaction in flight.
          data_d   = bus.data_i[pick];
`ifdef BR_TX_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end

      ST_REQ: begin
        // Ack is checked first so a simultaneous expiry resolves to ack.
        if (bus.br_ack_i) begin
          gnt_d[winner_q] = 1'b1;
          rr_d            = winner_q;
          state_d         = ST_GAP;
        end
`ifdef BR_TX_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          rr_d      = winner_q;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      winner_q  <= '0;
      // Last-served index starts at the top so requester 0 is first.
      rr_q      <= IDX_W'(N_REQ - 1);
      data_q    <= '0;
      gnt_q     <= '0;
`ifdef BR_TX_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      gnt_q     <= gnt_d;
`ifdef BR_TX_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // br_req_o is decoded straight from the state register so an asynchronous
  // reset drops it immediately.
  assign bus.br_req_o  = (state_q == ST_REQ);
  assign bus.br_data_o = data_q;
  assign bus.gnt_o     = gnt_q;
  assign busy_o        = (state_q != ST_IDLE);

`ifdef BR_TX_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
